// File: rtl/sq_pkg.sv
// Shared definitions for the SQ_1011 serial-bit interface: transmitter
// state encoding, the reference pattern and the repeat-count width.
package sq_pkg;

  localparam int SQ_REPEAT_W = 4;

  localparam logic [3:0] SQ_PATTERN_1011 = 4'b1011;

  typedef enum logic [1:0] {
    SQ_IDLE  = 2'd0,
    SQ_SHIFT = 2'd1,
    SQ_GAP   = 2'd2
  } sq_tx_state_t;

endpackage

// File: rtl/sq_down_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and
// the count holds at zero rather than wrapping.
module sq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sq_pattern_tx.sv
// Serial pattern transmitter: accepts a word on a valid/ready handshake and
// shifts it out MSB-first, repeating it with optional zero-filled gaps.
module sq_pattern_tx
  import sq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   LOAD_valid,
  output logic                   LOAD_ready,
  input  logic [WIDTH-1:0]       LOAD_data,
  input  logic [SQ_REPEAT_W-1:0] LOAD_repeat,
  output logic                   S_output,
  output logic                   S_valid,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] ST_IDLE  = SQ_IDLE;
  localparam logic [1:0] ST_SHIFT = SQ_SHIFT;
  localparam logic [1:0] ST_GAP   = SQ_GAP;

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

  // Handshake: a word transfers on the rising edge where LOAD_valid and
  // LOAD_ready are both 1; LOAD_ready depends on state only, never on LOAD_valid.
  logic accept;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] word;
  logic             done_n;

  logic bit_load, bit_dec, bit_zero;
  logic gap_load, gap_dec, gap_zero;
  logic rep_load, rep_dec, rep_zero;

  assign LOAD_ready = (state == ST_IDLE) && !RST;
  assign accept     = LOAD_valid && LOAD_ready;
  assign state_dbg  = state;

  sq_down_counter #(.W(BIT_W)) u_bit_cnt (
    .clk        (CLK),
    .rst        (RST),
    .load       (bit_load),
    .load_value (BIT_LOAD),
    .dec        (bit_dec),
    .zero       (bit_zero)
  );

  sq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk        (CLK),
    .rst        (RST),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .dec        (gap_dec),
    .zero       (gap_zero)
  );

  sq_down_counter #(.W(SQ_REPEAT_W)) u_rep_cnt (
    .clk        (CLK),
    .rst        (RST),
    .load       (rep_load),
    .load_value (LOAD_repeat),
    .dec        (rep_dec),
    .zero       (rep_zero)
  );

  always_comb begin
    state_n  = state;
    sr_n     = sr;
    done_n   = 1'b0;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n  = ST_SHIFT;
          sr_n     = LOAD_data;
          bit_load = 1'b1;
          rep_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!bit_zero) begin
          sr_n    = sr << 1;
          bit_dec = 1'b1;
        end else if (rep_zero) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          rep_dec = 1'b1;
          sr_n    = word;
          // With no gap the next repetition follows the last bit directly.
          if (GAP == 0) begin
            bit_load = 1'b1;
          end else begin
            state_n  = ST_GAP;
            gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_n  = ST_SHIFT;
          bit_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state they describe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      sr       <= '0;
      word     <= '0;
      S_output <= 1'b0;
      S_valid  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      if (accept) word <= LOAD_data;
      S_output <= (state_n == ST_SHIFT) && sr_n[WIDTH-1];
      S_valid  <= (state_n == ST_SHIFT);
      BUSY     <= (state_n != ST_IDLE);
      DONE     <= done_n;
    end
  end

endmodule

// File: tb/tb_sq_pattern_tx.sv
// Bench for sq_pattern_tx: one instance with GAP=1 and one with GAP=0,
// compared per cycle against a stream model built from the transmit rules.
module tb_sq_pattern_tx;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv1 = 1'b0;
  logic       lv0 = 1'b0;
  logic [3:0] data = '0;
  logic [3:0] rep = '0;

  logic rdy1, so1, sv1, busy1, done1;
  logic rdy0, so0, sv0, busy0, done0;
  logic [1:0] st1, st0;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle vector {S_output, S_valid, BUSY, DONE, LOAD_ready}
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  sq_pattern_tx #(.WIDTH(W), .GAP(1)) u_gap1 (
    .CLK(clk), .RST(rst), .LOAD_valid(lv1), .LOAD_ready(rdy1),
    .LOAD_data(data), .LOAD_repeat(rep), .S_output(so1), .S_valid(sv1),
    .BUSY(busy1), .DONE(done1), .state_dbg(st1)
  );

  sq_pattern_tx #(.WIDTH(W), .GAP(0)) u_gap0 (
    .CLK(clk), .RST(rst), .LOAD_valid(lv0), .LOAD_ready(rdy0),
    .LOAD_data(data), .LOAD_repeat(rep), .S_output(so0), .S_valid(sv0),
    .BUSY(busy0), .DONE(done0), .state_dbg(st0)
  );

  function automatic logic [4:0] obs(input int gap);
    if (gap == 0) return {so0, sv0, busy0, done0, rdy0};
    return {so1, sv1, busy1, done1, rdy1};
  endfunction

  // Model: rep+1 copies of the word MSB-first, gap zero cycles between
  // copies, then a single DONE cycle with the transmitter ready again.
  function automatic void push_expected(input logic [3:0] w, input int r, input int gap);
    for (int k = 0; k <= r; k++) begin
      for (int i = 0; i < W; i++) exp_q.push_back({w[W-1-i], 4'b1100});
      if (k < r) for (int g = 0; g < gap; g++) exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00011);
  endfunction

  task automatic start(input int gap, input logic [3:0] w, input logic [3:0] r);
    @(negedge clk);
    data = w;
    rep  = r;
    if (gap == 0) lv0 = 1'b1; else lv1 = 1'b1;
    @(posedge clk);
  endtask

  task automatic check_q(input int gap, input string name, input int drop_at,
                         input logic [3:0] next_w, output int det);
    int c = 0;
    logic [3:0] hist = '0;
    logic [4:0] exp_v, got;
    det = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (c == 0 && drop_at != 0) data = next_w;
      if (c == drop_at) begin
        lv0 = 1'b0; lv1 = 1'b0;
        data = 4'($urandom); rep = 4'($urandom);
      end
      exp_v = exp_q.pop_front();
      got = obs(gap);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s gap=%0d cyc=%0d got=%b exp=%b", name, gap, c, got, exp_v);
      end
      hist = {hist[2:0], got[4]};
      if (hist == 4'b1011) det++;
      c++;
    end
  endtask

  task automatic check_det(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s detections got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  task automatic check_idle(input string name, input logic [4:0] exp_v);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (obs(g) !== exp_v) begin
        errors++;
        $display("FAIL %s gap=%0d got=%b exp=%b", name, g, obs(g), exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_hold", 5'b00000);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_release", 5'b00001);
  endtask

  task automatic run_one(input int gap, input string name, input logic [3:0] w,
                         input logic [3:0] r, input int exp_det);
    int det;
    push_expected(w, int'(r), gap);
    exp_q.push_back(5'b00001);
    start(gap, w, r);
    check_q(gap, name, 0, 4'h0, det);
    if (exp_det >= 0) check_det(name, det, exp_det);
  endtask

  task automatic test_single();
    run_one(1, "single", 4'b1011, 4'd0, 1);
  endtask

  task automatic test_repeat_gap();
    run_one(1, "repeat_gap", 4'b1011, 4'd1, 2);
  endtask

  task automatic test_back_to_back();
    run_one(0, "back_to_back", 4'b1011, 4'd2, 3);
  endtask

  task automatic test_handshake();
    int det;
    push_expected(4'b1011, 0, 1);
    push_expected(4'b0110, 0, 1);
    exp_q.push_back(5'b00001);
    start(1, 4'b1011, 4'd0);
    check_q(1, "handshake", 5, 4'b0110, det);
    check_det("handshake", det, 1);
  endtask

  task automatic test_reset_mid();
    int det;
    exp_q.push_back(5'b11100);
    exp_q.push_back(5'b01100);
    start(1, 4'b1011, 4'd3);
    check_q(1, "reset_mid", 0, 4'h0, det);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("reset_mid_clear", 5'b00000);
    @(negedge clk);
    check_idle("reset_mid_hold", 5'b00000);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_release", 5'b00001);
    run_one(1, "after_reset", 4'b1011, 4'd0, 1);
  endtask

  task automatic test_edge_patterns();
    run_one(1, "all_zero", 4'b0000, 4'd0, 0);
    run_one(0, "all_one", 4'b1111, 4'd0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int g;
      g = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_one(g, "random", 4'($urandom), 4'($urandom_range(0, 3)), -1);
    end
    run_one(1, "max_repeat", 4'b1001, 4'd15, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_back_to_back();
    test_handshake();
    test_reset_mid();
    test_edge_patterns();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
